// File: rtl/sdram_frame_reader.sv
// sdram_frame_reader: Avalon-MM pipelined read master that streams one frame
// of 16-bit pixels from SDRAM into a show-ahead FIFO with valid/ready output.
// A credit counter sized to the FIFO throttles requests so returning read data
// always has a free FIFO slot.
module sdram_frame_reader #(
    parameter logic [24:0] BASE_ADDR   = 25'd0,
    parameter int unsigned FRAME_WORDS = 307200,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [24:0] sdram_address,
    output logic [1:0]  sdram_byteenable_n,
    output logic        sdram_chipselect,
    output logic [15:0] sdram_writedata,
    output logic        sdram_read_n,
    output logic        sdram_write_n,
    input  logic [15:0] sdram_readdata,
    input  logic        sdram_readdatavalid,
    input  logic        sdram_waitrequest,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [25:0]   FRAME_C = 26'(FRAME_WORDS);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]    state;
    logic [24:0]   addr;          // address of the current / next request
    logic [25:0]   remaining;     // requests not yet accepted in this frame
    logic          read_n;
    logic [CW-1:0] credits_used;  // requests asserted but not yet popped
    logic [CW-1:0] pending;       // requests accepted but data not yet returned
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic [15:0]   mem [FIFO_DEPTH];

    logic start_ok;
    logic accepted;
    logic have_credit;
    logic last_accept;
    logic assert_req;
    logic push;
    logic pop;
    logic fifo_empty;

    // Request/credit decisions for this cycle.
    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        start_ok    = start & (state == IDLE) & ~done;
        accepted    = ~read_n & ~sdram_waitrequest;
        have_credit = credits_used < DEPTH_C;
        last_accept = (state == ISSUE) & accepted & (remaining == 26'd1);
        assert_req  = 1'b0;
        if (start_ok) begin
            assert_req = have_credit;
        end else if (state == ISSUE) begin
            if (accepted)
                assert_req = have_credit & (remaining > 26'd1);
            else if (read_n)
                assert_req = have_credit;
        end
        push       = sdram_readdatavalid & (pending != '0);
        fifo_empty = (wr_ptr == rd_ptr);
        pop        = pix_ready & ~fifo_empty;
    end

    // Frame FSM, request address/count and the Avalon read strobe.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            read_n    <= 1'b1;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state     <= ISSUE;
                        addr      <= BASE_ADDR;
                        remaining <= FRAME_C;
                    end
                end
                ISSUE: begin
                    if (accepted) begin
                        addr      <= addr + 25'd1;
                        remaining <= remaining - 26'd1;
                    end
                    if (last_accept)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (push && pending == CW'(1)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // A stalled request holds; otherwise read_n reflects the new-request decision.
            read_n <= ~((~read_n & ~accepted) | assert_req);
        end
    end

    // Credit and outstanding-read counters plus FIFO pointers.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            credits_used <= '0;
            pending      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else begin
            credits_used <= credits_used + CW'(assert_req) - CW'(pop);
            pending      <= pending + CW'(accepted) - CW'(push);
            if (push)
                wr_ptr <= wr_ptr + CW'(1);
            if (pop)
                rd_ptr <= rd_ptr + CW'(1);
        end
    end

    // FIFO storage write port.
    // NOTE: the data array has no reset; pointers alone define validity, and pix_data is forced to 0 when empty.
    always_ff @(posedge clk_clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= sdram_readdata;
    end

    assign pix_valid          = ~fifo_empty;
    assign pix_data           = fifo_empty ? 16'd0 : mem[rd_ptr[AW-1:0]];
    assign busy               = (state != IDLE) | done;
    assign sdram_address      = addr;
    assign sdram_read_n       = read_n;
    assign sdram_chipselect   = ~read_n;
    assign sdram_byteenable_n = 2'b00;
    assign sdram_writedata    = 16'd0;
    assign sdram_write_n      = 1'b1;
endmodule

// File: tb/tb_sdram_frame_reader.sv
// Testbench for sdram_frame_reader: two instances (BASE 0x100 / depth 16 and
// BASE 0x1FFFFFE / depth 4, both 8-word frames) driven by a 2-cycle-latency
// SDRAM slave model, with a pixel scoreboard and request-address tracking.
module tb_sdram_frame_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst;
    logic [1:0]  start;
    logic [1:0]  pix_ready;
    logic [1:0]  waitreq = 2'b00;
    logic [1:0]  rdv = 2'b00;
    logic [15:0] rdata [2];
    wire  [1:0]  busy, done, cs, rd_n, wr_n, pix_valid;
    wire  [24:0] addr [2];
    wire  [1:0]  be_n [2];
    wire  [15:0] wdata [2];
    wire  [15:0] pix [2];

    sdram_frame_reader #(.BASE_ADDR(25'h100), .FRAME_WORDS(8), .FIFO_DEPTH(16)) u_dut_a (
        .clk_clk(clk), .reset_reset(rst[0]), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .sdram_address(addr[0]), .sdram_byteenable_n(be_n[0]), .sdram_chipselect(cs[0]),
        .sdram_writedata(wdata[0]), .sdram_read_n(rd_n[0]), .sdram_write_n(wr_n[0]),
        .sdram_readdata(rdata[0]), .sdram_readdatavalid(rdv[0]), .sdram_waitrequest(waitreq[0]),
        .pix_data(pix[0]), .pix_valid(pix_valid[0]), .pix_ready(pix_ready[0]));

    sdram_frame_reader #(.BASE_ADDR(25'h1FFFFFE), .FRAME_WORDS(8), .FIFO_DEPTH(4)) u_dut_b (
        .clk_clk(clk), .reset_reset(rst[1]), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .sdram_address(addr[1]), .sdram_byteenable_n(be_n[1]), .sdram_chipselect(cs[1]),
        .sdram_writedata(wdata[1]), .sdram_read_n(rd_n[1]), .sdram_write_n(wr_n[1]),
        .sdram_readdata(rdata[1]), .sdram_readdatavalid(rdv[1]), .sdram_waitrequest(waitreq[1]),
        .pix_data(pix[1]), .pix_valid(pix_valid[1]), .pix_ready(pix_ready[1]));

    int checks = 0;
    int errors = 0;

    logic        cur = 1'b0;     // instance under test
    logic        stray = 1'b0;   // inject a readdatavalid with nothing outstanding
    logic [15:0] exp_q [$];      // expected pixel stream
    logic [24:0] acc_log [$];    // accepted request addresses
    logic [24:0] exp_addr = '0;
    int          acc_cnt = 0;
    int          done_cnt = 0;
    int          stall_at = 0;
    int          stall_left = 0;
    int          cyc = 0;
    int          first_acc = 0;
    int          last_acc = 0;
    logic        stall_now = 1'b0;
    logic        was_stalled = 1'b0;
    logic        accept_now = 1'b0;
    logic        d1_v = 1'b0, d2_v = 1'b0;
    logic [24:0] d1_a = '0, d2_a = '0;
    logic        hold_v = 1'b0;
    logic [15:0] hold_d = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [24:0] a);
        return {a[7:0], a[15:8]} ^ {7'd0, a[24:16]} ^ 16'h5AC3;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Slave model, request tracking and pixel scoreboard; samples mid-cycle.
    always @(negedge clk) begin
        cyc++;
        stall_now = 1'b0;
        if (!rst[cur] && !rd_n[cur] && stall_left > 0 && acc_cnt == stall_at) begin
            stall_now = 1'b1;
            stall_left--;
        end
        waitreq[cur] = stall_now;
        if (was_stalled) check("read_n_held", 32'(rd_n[cur]), 32'd0);
        accept_now = 1'b0;
        if (!rd_n[cur]) begin
            check("req_addr", 32'(addr[cur]), 32'(exp_addr));
            check("chipselect", 32'(cs[cur]), 32'd1);
            if (!stall_now) begin
                accept_now = 1'b1;
                if (acc_cnt == 0) first_acc = cyc;
                last_acc = cyc;
                acc_log.push_back(addr[cur]);
                acc_cnt++;
                exp_addr = exp_addr + 25'd1;
            end
        end
        was_stalled = stall_now;
        rdv[cur]   = d2_v | stray;
        rdata[cur] = d2_v ? mem_word(d2_a) : 16'hBAD0;
        d2_v = d1_v;
        d2_a = d1_a;
        d1_v = accept_now;
        d1_a = addr[cur];
        if (pix_valid[cur] && hold_v) check("pix_hold", 32'(pix[cur]), 32'(hold_d));
        if (pix_valid[cur] && pix_ready[cur]) begin
            if (exp_q.size() == 0) check("pix_unexpected", 32'(exp_q.size()), 32'd1);
            else check("pix_data", 32'(pix[cur]), 32'(exp_q.pop_front()));
        end
        hold_v = pix_valid[cur] & ~pix_ready[cur];
        hold_d = pix[cur];
        if (done[cur]) begin
            done_cnt++;
            check("busy_at_done", 32'(busy[cur]), 32'd1);
        end
    end

    task automatic check_reset(input logic k);
        check("rst_read_n", 32'(rd_n[k]), 32'd1);
        check("rst_cs", 32'(cs[k]), 32'd0);
        check("rst_addr", 32'(addr[k]), 32'd0);
        check("rst_busy", 32'(busy[k]), 32'd0);
        check("rst_done", 32'(done[k]), 32'd0);
        check("rst_pix_valid", 32'(pix_valid[k]), 32'd0);
        check("rst_pix_data", 32'(pix[k]), 32'd0);
        check("const_write_n", 32'(wr_n[k]), 32'd1);
        check("const_be_n", 32'(be_n[k]), 32'd0);
        check("const_wdata", 32'(wdata[k]), 32'd0);
    endtask

    task automatic start_frame(input logic [24:0] base);
        exp_addr = base;
        acc_cnt  = 0;
        done_cnt = 0;
        acc_log.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(mem_word(base + 25'(i)));
        start[cur] = 1'b1;
        tick();
        start[cur] = 1'b0;
        check("start_busy", 32'(busy[cur]), 32'd1);
        check("start_read_n", 32'(rd_n[cur]), 32'd0);
        check("start_addr", 32'(addr[cur]), 32'(base));
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 400) begin
            tick();
            n++;
        end
        check("done_seen", 32'(done_cnt), 32'd1);
        check("busy_after_done", 32'(busy[cur]), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();
        check("idle_pix_valid", 32'(pix_valid[cur]), 32'd0);
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("accept_count", 32'(acc_cnt), 32'd8);
    endtask

    initial begin
        int n;
        rst = 2'b11;
        start = 2'b00;
        pix_ready = 2'b00;
        repeat (3) tick();
        check_reset(1'b0);
        check_reset(1'b1);
        rst = 2'b00;
        repeat (2) tick();

        // Straight frame: 8 back-to-back requests at 0x100.
        cur = 1'b0;
        pix_ready[0] = 1'b1;
        start_frame(25'h100);
        wait_done();
        drain();
        check("t1_accept_span", 32'(last_acc - first_acc), 32'd7);

        // Three-cycle stall on the third request.
        stall_at = 2;
        stall_left = 3;
        start_frame(25'h100);
        wait_done();
        drain();
        check("t2_accept_span", 32'(last_acc - first_acc), 32'd10);

        // Depth-4 credit limit plus 25-bit address wrap.
        cur = 1'b1;
        pix_ready[1] = 1'b0;
        start_frame(25'h1FFFFFE);
        repeat (20) tick();
        check("credit_accepts", 32'(acc_cnt), 32'd4);
        check("credit_read_n", 32'(rd_n[1]), 32'd1);
        check("credit_pix_valid", 32'(pix_valid[1]), 32'd1);
        check("credit_busy", 32'(busy[1]), 32'd1);
        pix_ready[1] = 1'b1;
        wait_done();
        drain();
        check("wrap_addr0", 32'(acc_log[0]), 32'h1FFFFFE);
        check("wrap_addr1", 32'(acc_log[1]), 32'h1FFFFFF);
        check("wrap_addr2", 32'(acc_log[2]), 32'h0000000);
        check("wrap_addr3", 32'(acc_log[3]), 32'h0000001);

        // Reset after 3 acceptances with reads still in flight.
        cur = 1'b0;
        start_frame(25'h100);
        n = 0;
        while (acc_cnt < 3 && n < 50) begin
            tick();
            n++;
        end
        rst[0] = 1'b1;
        exp_q.delete();
        @(negedge clk);
        #1;
        check("mid_rst_accepts", 32'(acc_cnt), 32'd3);
        check("mid_rst_read_n", 32'(rd_n[0]), 32'd1);
        check("mid_rst_pix_valid", 32'(pix_valid[0]), 32'd0);
        check("mid_rst_busy", 32'(busy[0]), 32'd0);
        tick();
        rst[0] = 1'b0;
        repeat (6) tick();
        check("late_data_dropped", 32'(pix_valid[0]), 32'd0);
        check("post_rst_read_n", 32'(rd_n[0]), 32'd1);
        start_frame(25'h100);
        wait_done();
        drain();

        // Stray readdatavalid while idle, then a second start mid-frame.
        stray = 1'b1;
        tick();
        stray = 1'b0;
        repeat (4) tick();
        check("stray_dropped", 32'(pix_valid[0]), 32'd0);
        start_frame(25'h100);
        repeat (3) tick();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        wait_done();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdram_frame_reader.md
# sdram_frame_reader

Avalon-MM pipelined read master that drives the SDRAM controller's `sdram_*` slave port. It fetches one frame of 16-bit pixels from a contiguous word-address range and presents them as a valid/ready pixel stream. The block sits between the SDRAM controller and the display/disparity consumer. A credit counter sized to its internal FIFO guarantees that returning read data is never dropped.

## Interface
Parameters:
- `BASE_ADDR`, 0: first word address of the frame (25-bit word address).
- `FRAME_WORDS`, 307200: number of 16-bit words per frame (640x480); range 1..2^25.
- `FIFO_DEPTH`, 16: pixel FIFO depth; power of two, range 4..256.

Ports:
- `clk_clk` in 1: single clock for all logic.
- `reset_reset` in 1: reset, asynchronous and active-high.
- `start` in 1: one-cycle pulse that begins a frame fetch; ignored while `busy`=1.
- `busy` out 1: high from the cycle after an accepted `start` until the `done` cycle, inclusive.
- `done` out 1: one-cycle pulse when the last frame word has been written into the FIFO.
- `sdram_address` out 25: word address of the current request.
- `sdram_byteenable_n` out 2: constant 2'b00.
- `sdram_chipselect` out 1: equals `~sdram_read_n`.
- `sdram_writedata` out 16: constant 0.
- `sdram_read_n` out 1: active-low read request.
- `sdram_write_n` out 1: constant 1.
- `sdram_readdata` in 16: returned read data.
- `sdram_readdatavalid` in 1: read data strobe.
- `sdram_waitrequest` in 1: slave stall.
- `pix_data` out 16: FIFO head.
- `pix_valid` out 1: FIFO non-empty.
- `pix_ready` in 1: consumer accepts `pix_data` when `pix_valid & pix_ready`.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE -> ISSUE on `start`. Load `addr`=BASE_ADDR and `remaining`=FRAME_WORDS.
  - ISSUE -> DRAIN on the cycle the last request is accepted.
  - DRAIN -> IDLE on the cycle `pending` reaches 0 after the last readdatavalid. `done`=1 in that cycle.
- A request is **accepted** in any cycle with `sdram_read_n`=0 and `sdram_waitrequest`=0.
- Once `sdram_read_n` goes low, `sdram_read_n` and `sdram_address` stay constant until acceptance (Avalon hold rule).
- `credits_used` counter, width log2(FIFO_DEPTH)+1:
  - +1 when a new request is first asserted.
  - -1 on a FIFO pop.
  - A new request is asserted (read_n driven low in the next cycle) only if `credits_used` < FIFO_DEPTH before this cycle's pop. The rule is conservative: same-cycle pop is not credited.
  - Invariant: `credits_used` <= FIFO_DEPTH, so the FIFO cannot overflow.
- Back-to-back issue:
  - After acceptance, if `remaining`>1 and credit is available, read_n stays low with `addr`+1.
  - Otherwise read_n goes high.
- Address arithmetic is 25-bit modulo 2^25. BASE_ADDR+FRAME_WORDS past 0x1FFFFFF wraps to 0.
- `pending` counter: +1 on acceptance, -1 on readdatavalid.
  - Readdatavalid with `pending`=0 is dropped and the FIFO is unchanged.
  - Accepted data is pushed into the FIFO.
- FIFO is show-ahead: `pix_data` is the head entry and is stable while `pix_valid & ~pix_ready`.
- FIFO contents persist after `done`. A following `start` appends the next frame behind the remaining words.
- `start` while `busy`=1 is ignored entirely.

## Timing
- Reset values:
  - `sdram_read_n`=1, `sdram_chipselect`=0, `sdram_address`=0.
  - `busy`=0, `done`=0, `pix_valid`=0, `pix_data`=0.
  - FSM=IDLE, FIFO empty, all counters 0.
- Reset mid-frame immediately deasserts read_n and empties the FIFO. Data still returning from the controller after reset hits `pending`=0 and is dropped.
- `start` at cycle t:
  - `busy`=1 at t+1.
  - First request (read_n=0, address=BASE_ADDR) visible at t+1.
- Throughput with waitrequest=0 and `pix_ready`=1 is one request per cycle.
- readdatavalid at cycle t gives `pix_valid`=1 and `pix_data` at t+1 (FIFO write latency 1).
- A push and a pop in the same cycle are both performed; FIFO count is unchanged.
- A push and a pop in the same cycle on an empty FIFO: no pop occurs (`pix_valid`=0), the push is performed, and `pix_valid`=1 next cycle.
- `done` is a single-cycle pulse. `busy` falls in the cycle after `done`.

## Test plan
- FRAME_WORDS=8, BASE_ADDR=0x100, waitrequest=0, fixed 2-cycle read latency, `pix_ready`=1 -> addresses 0x100..0x107 accepted on 8 consecutive cycles. Pix stream equals memory words in order. One `done` pulse; `busy` low afterwards.
- Same setup with waitrequest high for 3 cycles on the 3rd request -> address 0x102 and read_n held constant through the stall. No duplicate or skipped address.
- FIFO_DEPTH=4, `pix_ready`=0 -> exactly 4 requests issued and read_n stays high. Raise `pix_ready` -> issue resumes one request per pop. Eight words delivered with no loss.
- BASE_ADDR=0x1FFFFFE, FRAME_WORDS=4 -> addresses 0x1FFFFFE, 0x1FFFFFF, 0x0000000, 0x0000001.
- Assert reset after 3 of 8 requests accepted, with 2 reads still outstanding -> read_n=1 and `pix_valid`=0 during reset. Late readdatavalid pulses are dropped. A fresh `start` then delivers 8 correct words.
- `start` pulsed again mid-frame, plus a stray readdatavalid while IDLE -> no restart, no FIFO write, frame completes normally.
